bit_deserializer: RTL and testbench
===================================

BIT_DESERIALIZER -- requirements
Module: bit_deserializer

Interface
REQ-001 Parameter: WIDTH, default 8, number of data bits per word (legal range 2..32).
REQ-002 Port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  begins (or restarts) word capture.
REQ-005 Port: bit_in  input  1  serial data bit, MSB first.
REQ-006 Port: bit_valid  input  1  bit_in is sampled on this edge.
REQ-007 Port: word_ready  input  1  downstream accepts word_out.
REQ-008 Port: clr_overrun  input  1  clears the sticky overrun flag.
REQ-009 Port: word_out  output  WIDTH  assembled word, held stable while word_valid=1.
REQ-010 Port: word_valid  output  1  word_out holds an unconsumed word.
REQ-011 Port: busy  output  1  high while the FSM is not in IDLE.
REQ-012 Port: overrun  output  1  sticky; a completed word was dropped.
REQ-013 Port: parity_err  output  1  parity mismatch on the word in word_out.

Function
REQ-014 FSM states: IDLE, SHIFT, PARITY (PARITY only with the REQ-031 macro defined).
REQ-015 IDLE -> SHIFT on start=1; bit count cleared; bit_in is not captured on the start edge, even if bit_valid=1.
REQ-016 In SHIFT, each edge with bit_valid=1 shifts bit_in into the LSB of the shift register, shifting left, and increments the bit count; bit_valid=0 holds state.
REQ-017 start=1 in SHIFT or PARITY aborts the partial word; the bit count is cleared and the FSM stays in or returns to SHIFT; no word is emitted.
REQ-018 On the edge accepting data bit WIDTH, the word is complete; without parity the FSM goes to IDLE, with parity it goes to PARITY.
REQ-019 Word load occurs on the completing edge (last data bit, or the parity bit): word_out <= {shift[WIDTH-2:0], bit_in}; word_valid=1 is visible in the following cycle (latency 0 edges after the last bit).
REQ-020 Handshake: word_valid and word_ready high on the same edge consume the word; word_valid falls unless a new load occurs on that edge.
REQ-021 A load while word_valid=1 and word_ready=1 replaces the word; word_valid stays 1 and overrun is unaffected.
REQ-022 A load while word_valid=1 and word_ready=0 drops the new word: word_out is unchanged, overrun <= 1, and the FSM still advances per REQ-018.
REQ-023 overrun is cleared by clr_overrun=1; if a set event and a clear coincide on one edge, the set wins.
REQ-024 busy = (state != IDLE), decoded combinationally from the state register.
REQ-025 word_ready has no effect while word_valid=0.

Reset
REQ-026 reset=1 forces, immediately and independent of clock: state=IDLE, bit count=0, shift register=0.
REQ-027 reset=1 also forces word_out=0, word_valid=0, overrun=0 and parity_err=0.
REQ-028 Reset asserted mid-word discards the partial word; no word is emitted after release.
REQ-029 After reset deasserts, the first transition requires start=1 on a rising edge.
REQ-030 Reset dominates all inputs, including start, bit_valid, word_ready and clr_overrun.

Configuration
REQ-031 Macro DESER_PARITY_EN, when defined, adds one even-parity bit after the WIDTH data bits.
REQ-032 With the macro, the parity bit is sampled in PARITY on bit_valid=1, and that edge is the load edge.
REQ-033 With the macro, parity_err loads with word_out: it is 1 when XOR(data bits, parity bit) = 1, and it is held with the word.
REQ-034 With the macro, a dropped word (REQ-022) leaves parity_err unchanged.
REQ-035 Without the macro, the PARITY state is absent, the word completes on data bit WIDTH, and parity_err is tied to 0; the port list is identical in both builds.

Verification
REQ-036 WIDTH=8: start, then bits 1,0,1,1,0,0,1,0 with word_ready=1 -> word_out=0xB2 and word_valid=1 for one cycle; busy falls with the load.
REQ-037 Complete word 0x5A with word_ready=0, then a second word 0x3C -> word_out stays 0x5A and overrun=1; a clr_overrun pulse -> overrun=0.
REQ-038 start after 4 bits, then a full word 0xFF -> word_out=0xFF; the aborted bits never appear on word_out.
REQ-039 reset=1 asserted between clock edges after 5 bits -> all outputs are 0 immediately; after release, bit_valid pulses without start give busy=0 and no word_valid.
REQ-040 DESER_PARITY_EN: word 0x03 with parity 0 -> parity_err=0; word 0x07 with parity 0 -> parity_err=1.
REQ-041 Load edge coinciding with word_ready=1 on a pending word -> word_valid stays 1, word_out takes the new value, and overrun=0.

Source files
------------

// File: rtl/bit_deserializer_if.sv
// bit_deserializer_if
//   Groups the serial-in / word-out handshake of bit_deserializer.
//   master : upstream source and downstream consumer (drives the serial
//            stream, word_ready and clr_overrun; observes the word side).
//   slave  : the deserializer itself.
//   Signals: start, bit_in, bit_valid, word_ready, clr_overrun (to slave);
//            word_out[WIDTH-1:0], word_valid, busy, overrun, parity_err
//            (from slave).
interface bit_deserializer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             bit_in;
  logic             bit_valid;
  logic             word_ready;
  logic             clr_overrun;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             busy;
  logic             overrun;
  logic             parity_err;

  modport master (
    output start, bit_in, bit_valid, word_ready, clr_overrun,
    input  word_out, word_valid, busy, overrun, parity_err
  );

  modport slave (
    input  start, bit_in, bit_valid, word_ready, clr_overrun,
    output word_out, word_valid, busy, overrun, parity_err
  );
endinterface

// File: rtl/bit_deserializer.sv
// bit_deserializer
//   Collects WIDTH serial bits (MSB first) into a word and presents it with
//   a valid/ready handshake. A word completing while the previous one is
//   still pending and not being accepted is dropped and flags a sticky
//   overrun.
//   Optional feature: define DESER_PARITY_EN to append one even-parity bit
//   after the data bits; parity_err reports a mismatch for the held word.
//   Without it parity_err is constant 0 and the port list is unchanged.
//   Ports:
//     clock - rising-edge clock
//     reset - asynchronous, active-high reset
//     bus   - bit_deserializer_if.slave (serial in, word out, status)
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   S_IDLE   | waiting for start
//   S_SHIFT  | collecting data bits
//   S_PARITY | waiting for the parity bit (DESER_PARITY_EN only)
module bit_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  bit_deserializer_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef DESER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  // All data bits must stay in the shifter until the parity bit arrives.
  localparam int SW = WIDTH;
`else
  localparam bit PAR_EN = 1'b0;
  // The last data bit is taken straight from bit_in on the load edge.
  localparam int SW = WIDTH - 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    shift_q, shift_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             perr_q, perr_d;

  logic             last_bit;
  logic             data_take;
  logic             load;
  logic [WIDTH-1:0] new_word;
  logic             new_perr;
  logic             busy;

  assign last_bit  = (cnt_q == CW'(WIDTH - 1));
  // start has priority: it never captures bit_in on its own edge.
  assign data_take = (state_q == S_SHIFT) && !bus.start && bus.bit_valid;

`ifdef DESER_PARITY_EN
  assign load     = (state_q == S_PARITY) && !bus.start && bus.bit_valid;
  assign new_word = shift_q;
  assign new_perr = (^shift_q) ^ bus.bit_in;
`else
  assign load     = data_take && last_bit;
  assign new_word = {shift_q, bus.bit_in};
  assign new_perr = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_SHIFT;
      S_SHIFT: begin
        if (bus.start)                  state_d = S_SHIFT;
        else if (data_take && last_bit) state_d = PAR_EN ? S_PARITY : S_IDLE;
      end
      S_PARITY: begin
        if (bus.start)          state_d = S_SHIFT;
        else if (bus.bit_valid) state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // Datapath and word handshake
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    word_d  = word_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    perr_d  = perr_q;

    if (bus.start) begin
      cnt_d = '0;
    end else if (data_take) begin
      cnt_d   = cnt_q + CW'(1);
      shift_d = SW'({shift_q, bus.bit_in});
    end

    // Clear first so a coinciding overrun set wins.
    if (bus.clr_overrun) ovr_d = 1'b0;

    if (load) begin
      if (valid_q && !bus.word_ready) begin
        ovr_d = 1'b1;
      end else begin
        word_d  = new_word;
        valid_d = 1'b1;
        perr_d  = new_perr;
      end
    end else if (valid_q && bus.word_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      perr_q  <= perr_d;
    end
  end

  assign bus.word_out   = word_q;
  assign bus.word_valid = valid_q;
  assign bus.busy       = busy;
  assign bus.overrun    = ovr_q;
  assign bus.parity_err = perr_q;

endmodule

// File: tb/tb_bit_deserializer.sv
// tb_bit_deserializer
//   Directed scenarios plus randomized traffic for bit_deserializer, checked
//   against a queue-based reference model of the word protocol.
//   Honours DESER_PARITY_EN the same way as the design.
module tb_bit_deserializer;

  localparam int W = 8;
`ifdef DESER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clock;
  logic reset;

  bit_deserializer_if #(.WIDTH(W)) bus_if ();

  bit_deserializer #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: bits collected since the last start, plus the
  // presented word and its status flags.
  bit       m_active;
  bit       m_in_par;
  int       m_bits[$];
  int       m_word;
  bit       m_valid;
  bit       m_ovr;
  bit       m_perr;

  task automatic model_reset();
    m_active = 0;
    m_in_par = 0;
    m_bits.delete();
    m_word   = 0;
    m_valid  = 0;
    m_ovr    = 0;
    m_perr   = 0;
  endtask

  task automatic model_edge(input bit s, input bit b, input bit v, input bit r, input bit c);
    bit complete;
    bit pbit;
    int w;
    int ones;
    complete = 0;
    pbit     = 0;
    if (s) begin
      m_active = 1;
      m_in_par = 0;
      m_bits.delete();
    end else if (m_active && v) begin
      if (m_in_par) begin
        complete = 1;
        pbit     = b;
      end else begin
        m_bits.push_back(int'(b));
        if (m_bits.size() == W) begin
          if (PAR) m_in_par = 1;
          else     complete = 1;
        end
      end
    end
    if (c) m_ovr = 0;
    if (complete) begin
      w    = 0;
      ones = 0;
      foreach (m_bits[i]) begin
        w    = w * 2 + m_bits[i];
        ones = ones + m_bits[i];
      end
      m_active = 0;
      m_in_par = 0;
      if (m_valid && !r) begin
        m_ovr = 1;
      end else begin
        m_word  = w;
        m_valid = 1;
        m_perr  = PAR ? bit'((ones + int'(pbit)) % 2) : 1'b0;
      end
    end else if (m_valid && r) begin
      m_valid = 0;
    end
  endtask

  task automatic compare_all(input string where);
    check({where, ".word_out"},   32'(bus_if.word_out),   32'(m_word));
    check({where, ".word_valid"}, 32'(bus_if.word_valid), 32'(m_valid));
    check({where, ".busy"},       32'(bus_if.busy),       32'(m_active));
    check({where, ".overrun"},    32'(bus_if.overrun),    32'(m_ovr));
    check({where, ".parity_err"}, 32'(bus_if.parity_err), 32'(m_perr));
  endtask

  // One clock cycle: drive after the falling edge, model the rising edge,
  // compare at the next falling edge.
  task automatic step(input bit s, input bit b, input bit v, input bit r, input bit c);
    bus_if.start       = s;
    bus_if.bit_in      = b;
    bus_if.bit_valid   = v;
    bus_if.word_ready  = r;
    bus_if.clr_overrun = c;
    @(posedge clock);
    model_edge(s, b, v, r, c);
    @(negedge clock);
    compare_all("step");
  endtask

  // start (with bit_valid=1 to show it is ignored), W data bits, then the
  // parity bit when enabled. r_last applies to the completing edge.
  task automatic send_word(input logic [W-1:0] w, input bit p, input bit r_bits, input bit r_last);
    step(1, 1, 1, r_bits, 0);
    for (int i = W - 1; i >= 0; i--)
      step(0, w[i], 1, (!PAR && i == 0) ? r_last : r_bits, 0);
    if (PAR) step(0, p, 1, r_last, 0);
  endtask

  // Reset asserted between clock edges; outputs must clear at once.
  task automatic mid_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all("async_rst");
    check("async_rst.word_out_zero", 32'(bus_if.word_out), 32'h0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    reset              = 1'b1;
    bus_if.start       = 0;
    bus_if.bit_in      = 0;
    bus_if.bit_valid   = 0;
    bus_if.word_ready  = 0;
    bus_if.clr_overrun = 0;
    repeat (2) @(negedge clock);
    compare_all("reset");
    reset = 1'b0;
    step(0, 1, 1, 1, 0);

    // Basic word with a ready consumer.
    send_word(8'hB2, ^8'hB2, 1, 1);
    check("b2.word", 32'(bus_if.word_out), 32'hB2);
    check("b2.valid", 32'(bus_if.word_valid), 32'h1);
    check("b2.busy", 32'(bus_if.busy), 32'h0);
    step(0, 0, 0, 1, 0);
    check("b2.valid_one_cycle", 32'(bus_if.word_valid), 32'h0);

    // Overrun: second word dropped while the first is pending.
    send_word(8'h5A, ^8'h5A, 0, 0);
    send_word(8'h3C, ^8'h3C, 0, 0);
    check("ovr.word_kept", 32'(bus_if.word_out), 32'h5A);
    check("ovr.flag", 32'(bus_if.overrun), 32'h1);
    step(0, 0, 0, 0, 1);
    check("ovr.cleared", 32'(bus_if.overrun), 32'h0);
    step(0, 0, 0, 1, 0);

    // Abort after 4 bits, then a full word.
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1'(i & 1), 1, 1, 0);
    send_word(8'hFF, ^8'hFF, 1, 1);
    check("abort.word", 32'(bus_if.word_out), 32'hFF);
    step(0, 0, 0, 1, 0);

    // Reset mid-word, then bit_valid pulses without start.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
    mid_reset();
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 1, 0);
      check("post_rst.busy", 32'(bus_if.busy), 32'h0);
      check("post_rst.valid", 32'(bus_if.word_valid), 32'h0);
    end

    // Load coinciding with acceptance of a pending word.
    send_word(8'h11, ^8'h11, 0, 0);
    send_word(8'h22, ^8'h22, 0, 1);
    check("replace.valid", 32'(bus_if.word_valid), 32'h1);
    check("replace.word", 32'(bus_if.word_out), 32'h22);
    check("replace.ovr", 32'(bus_if.overrun), 32'h0);
    step(0, 0, 0, 1, 0);

`ifdef DESER_PARITY_EN
    send_word(8'h03, 1'b0, 1, 1);
    check("par03.err", 32'(bus_if.parity_err), 32'h0);
    step(0, 0, 0, 1, 0);
    send_word(8'h07, 1'b0, 1, 1);
    check("par07.err", 32'(bus_if.parity_err), 32'h1);
    step(0, 0, 0, 1, 0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        mid_reset();
      end else begin
        step(($urandom_range(0, 24) == 0),
             1'($urandom),
             ($urandom_range(0, 9) < 6),
             ($urandom_range(0, 9) < 3),
             ($urandom_range(0, 9) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
